gray_ptr_receiver: RTL

Read-side pointer receiver for the asynchronous FIFO: the consuming end of the gray-coded write pointer that `graycounter` produces in the write clock domain. It synchronises the incoming gray write pointer into the read clock, decodes it to binary, and maintains the local read pointer. From these it produces empty/level status, the RAM read address and a gray read pointer for return to the write side.

---
 rtl/async_fifo_pkg.sv | 21 ++
 rtl/ptr_sync.sv | 30 +++
 rtl/gray_ptr_receiver.sv | 80 ++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default pointer width and gray/binary
// conversion helpers used by both the write and read pointer blocks.
package async_fifo_pkg;

    localparam int CTR_W_DEF = 4;

    // Operates on a zero-extended 32-bit value; callers truncate to width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-stage flop chain carrying a gray pointer across clock domains,
// with synchronous clear.
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             clr_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk) begin
        if (clr_in) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Read-side pointer receiver: syncs the gray write pointer, keeps the read
// pointer and produces empty/level/error status plus the return gray pointer.
module gray_ptr_receiver
    import async_fifo_pkg::*;
#(
    parameter int counter_width = CTR_W_DEF,
    parameter int sync_stages   = 2
) (
    input  logic                     clk,
    input  logic                     clr_in,
    input  logic [counter_width-1:0] wgray_in,
    input  logic                     rd_en_in,
    output logic                     rd_ack_out,
    output logic [counter_width-2:0] raddr_out,
    output logic [counter_width-1:0] rgray_out,
    output logic                     empty_out,
    output logic [counter_width-1:0] level_out,
    output logic                     err_out
);

    localparam int W = counter_width;
    localparam logic [W-1:0] DEPTH = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] wsync;
    logic [W-1:0] wbin;
    logic [W-1:0] rbin_q, rbin_d;
    logic [W-1:0] rgray_q, rgray_d;
    logic [W-1:0] level_q, level_d;
    logic         empty_q, empty_d;
    logic         ack_q;
    logic         err_q, err_d;
    logic         pop;

    ptr_sync #(
        .WIDTH (W),
        .STAGES(sync_stages)
    ) u_wsync (
        .clk   (clk),
        .clr_in(clr_in),
        .d_in  (wgray_in),
        .q_out (wsync)
    );

    always_comb begin
        wbin    = W'(gray2bin(32'(wsync)));
        pop     = rd_en_in & ~empty_q;
        rbin_d  = rbin_q + {{(W-1){1'b0}}, pop};
        rgray_d = W'(bin2gray(32'(rbin_d)));
        level_d = wbin - rbin_d;
        empty_d = (rgray_d == wsync);
        // Underflow attempt or a write pointer that leapt past a full FIFO
        err_d   = err_q | (rd_en_in & empty_q) | (level_d > DEPTH);
    end

    always_ff @(posedge clk) begin
        if (clr_in) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            level_q <= level_d;
            empty_q <= empty_d;
            ack_q   <= pop;
            err_q   <= err_d;
        end
    end

    assign rd_ack_out = ack_q;
    assign raddr_out  = rbin_q[W-2:0];
    assign rgray_out  = rgray_q;
    assign empty_out  = empty_q;
    assign level_out  = level_q;
    assign err_out    = err_q;

endmodule
